// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipeline_ctrl_pkg;

  localparam int REG_IDX_W = 5;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  // Wait counter needs at least 8 bits and must be able to hold the timeout value.
  function automatic int wait_cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w > 8) ? w : 8;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_perf_cnt.sv
// Saturating 32-bit event counter with enable, used for pipeline performance counters.
module pipe_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  output logic [31:0] o_count
);

  logic [31:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 32'd0;
    end else if (i_en && (r_count != 32'hFFFFFFFF)) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: memory-wait FSM with timeout, redirect and load-use handling.
// Optional performance counters are enabled by defining PIPELINE_CTRL_PERF_CNT_EN.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] D_rs1,
  input  logic [REG_IDX_W-1:0] D_rs2,
  input  logic                 D_use_rs1,
  input  logic                 D_use_rs2,
  input  logic [REG_IDX_W-1:0] E_rd,
  input  logic                 E_is_load,
  input  logic                 E_redirect,
  input  logic                 M_mem_req,
  input  logic                 dmem_ack,
  output logic                 F_stall,
  output logic                 D_stall,
  output logic                 E_stall,
  output logic                 M_stall,
  output logic                 D_flush,
  output logic                 E_flush,
  output logic                 mem_err,
  output logic [31:0]          stall_cycles,
  output logic [31:0]          flush_events
);

  localparam int CNT_W = wait_cnt_width(MEM_TIMEOUT);
  localparam int LIM = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(LIM);

  state_t           r_state;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_mem_err;

  logic w_mem_stall;
  logic w_load_use;

  assign w_mem_stall = ((r_state == IDLE) && M_mem_req && !dmem_ack) ||
                       ((r_state == MEM_WAIT) && !dmem_ack);

  assign w_load_use = E_is_load && (E_rd != '0) &&
                      ((D_use_rs1 && (D_rs1 == E_rd)) || (D_use_rs2 && (D_rs2 == E_rd)));

  // Priority: memory stall, then redirect, then load-use; ERR and reset force everything low.
  always_comb begin
    F_stall = 1'b0;
    D_stall = 1'b0;
    E_stall = 1'b0;
    M_stall = 1'b0;
    D_flush = 1'b0;
    E_flush = 1'b0;
    if (!rst && (r_state != ERR)) begin
      if (w_mem_stall) begin
        F_stall = 1'b1;
        D_stall = 1'b1;
        E_stall = 1'b1;
        M_stall = 1'b1;
      end else if (E_redirect) begin
        D_flush = 1'b1;
        E_flush = 1'b1;
      end else if (w_load_use) begin
        F_stall = 1'b1;
        D_stall = 1'b1;
        E_flush = 1'b1;
      end
    end
  end

  // The wait counter only advances below WAIT_LIM, so it can never wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_mem_err <= 1'b0;
          if (M_mem_req && !dmem_ack) begin
            r_state    <= MEM_WAIT;
            r_wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (dmem_ack) begin
            r_state <= IDLE;
          end else if (r_wait_cnt >= WAIT_LIM) begin
            r_state   <= ERR;
            r_mem_err <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        ERR: begin
          r_state   <= IDLE;
          r_mem_err <= 1'b0;
        end
        default: begin
          r_state   <= IDLE;
          r_mem_err <= 1'b0;
        end
      endcase
    end
  end

  assign mem_err = r_mem_err;

`ifdef PIPELINE_CTRL_PERF_CNT_EN
  pipe_perf_cnt u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (F_stall),
    .o_count (stall_cycles)
  );

  pipe_perf_cnt u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (D_flush | E_flush),
    .o_count (flush_events)
  );
`else
  assign stall_cycles = 32'd0;
  assign flush_events = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed hazard scenarios followed by random cycles,
// compared against a cycle-level reference model of outstanding memory accesses.
module tb_pipeline_ctrl;

  localparam int TIMEOUT = 4;

  logic        clk;
  logic        rst;
  logic [4:0]  D_rs1, D_rs2, E_rd;
  logic        D_use_rs1, D_use_rs2, E_is_load, E_redirect, M_mem_req, dmem_ack;
  logic        F_stall, D_stall, E_stall, M_stall, D_flush, E_flush, mem_err;
  logic [31:0] stall_cycles, flush_events;

  int n_vectors = 0;
  int n_miscompares = 0;

  // Reference model state: consecutive stalled cycles of the current access, pending error pulse.
  int          ms_pending = 0;
  bit          ms_err = 1'b0;
  bit          ms_known = 1'b0;
  logic [31:0] ms_stall_cnt = 32'd0;
  logic [31:0] ms_flush_cnt = 32'd0;

  pipeline_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .D_rs1        (D_rs1),
    .D_rs2        (D_rs2),
    .D_use_rs1    (D_use_rs1),
    .D_use_rs2    (D_use_rs2),
    .E_rd         (E_rd),
    .E_is_load    (E_is_load),
    .E_redirect   (E_redirect),
    .M_mem_req    (M_mem_req),
    .dmem_ack     (dmem_ack),
    .F_stall      (F_stall),
    .D_stall      (D_stall),
    .E_stall      (E_stall),
    .M_stall      (M_stall),
    .D_flush      (D_flush),
    .E_flush      (E_flush),
    .mem_err      (mem_err),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_result(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit r, input logic [4:0] rs1, input logic [4:0] rs2,
                      input bit u1, input bit u2, input logic [4:0] erd, input bit eload,
                      input bit redir, input bit req, input bit ack);
    bit mem_stall, load_use;
    bit e_fs, e_ds, e_es, e_ms, e_df, e_ef;
    rst = r; D_rs1 = rs1; D_rs2 = rs2; D_use_rs1 = u1; D_use_rs2 = u2;
    E_rd = erd; E_is_load = eload; E_redirect = redir; M_mem_req = req; dmem_ack = ack;
    @(negedge clk);
    {e_fs, e_ds, e_es, e_ms, e_df, e_ef} = 6'b0;
    mem_stall = ((ms_pending > 0) || req) && !ack;
    load_use = eload && (erd != 5'd0) && ((u1 && rs1 == erd) || (u2 && rs2 == erd));
    if (!r && !ms_err) begin
      if (mem_stall) {e_fs, e_ds, e_es, e_ms} = 4'b1111;
      else if (redir) {e_df, e_ef} = 2'b11;
      else if (load_use) {e_fs, e_ds, e_ef} = 3'b111;
    end
    check_result("F_stall", 32'(F_stall), 32'(e_fs));
    check_result("D_stall", 32'(D_stall), 32'(e_ds));
    check_result("E_stall", 32'(E_stall), 32'(e_es));
    check_result("M_stall", 32'(M_stall), 32'(e_ms));
    check_result("D_flush", 32'(D_flush), 32'(e_df));
    check_result("E_flush", 32'(E_flush), 32'(e_ef));
    if (ms_known) begin
      check_result("mem_err", 32'(mem_err), 32'(ms_err));
      check_result("stall_cycles", stall_cycles, ms_stall_cnt);
      check_result("flush_events", flush_events, ms_flush_cnt);
    end
    $display("t=%0t rst=%0b req=%0b ack=%0b redir=%0b ld=%0b rd=%0d rs=%0d/%0d -> st=%b%b%b%b fl=%b%b err=%0b sc=%0d fc=%0d",
             $time, r, req, ack, redir, eload, erd, rs1, rs2,
             F_stall, D_stall, E_stall, M_stall, D_flush, E_flush, mem_err, stall_cycles, flush_events);
    @(posedge clk);
    if (r) begin
      ms_pending = 0; ms_err = 1'b0; ms_known = 1'b1;
      ms_stall_cnt = 32'd0; ms_flush_cnt = 32'd0;
    end else begin
`ifdef PIPELINE_CTRL_PERF_CNT_EN
      if (e_fs && ms_stall_cnt != 32'hFFFFFFFF) ms_stall_cnt = ms_stall_cnt + 32'd1;
      if ((e_df || e_ef) && ms_flush_cnt != 32'hFFFFFFFF) ms_flush_cnt = ms_flush_cnt + 32'd1;
`endif
      if (ms_err) begin
        ms_err = 1'b0;
      end else if (mem_stall) begin
        // One stalled request cycle plus TIMEOUT waiting cycles exhausts the access.
        ms_pending++;
        if (ms_pending == TIMEOUT + 1) begin
          ms_pending = 0;
          ms_err = 1'b1;
        end
      end else begin
        ms_pending = 0;
      end
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; D_rs1 = '0; D_rs2 = '0; D_use_rs1 = 0; D_use_rs2 = 0;
    E_rd = '0; E_is_load = 0; E_redirect = 0; M_mem_req = 0; dmem_ack = 0;

    //   rst rs1   rs2   u1 u2 erd   ld rd rq ak
    step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
    step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
    step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
    // load-use then bubble
    step(0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 0, 0);
    step(0, 5'd5, 5'd0, 1, 0, 5'd0, 0, 0, 0, 0);
    // rs2 match, and x0 never matches
    step(0, 5'd1, 5'd9, 1, 1, 5'd9, 1, 0, 0, 0);
    step(0, 5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 0);
    // redirect beats load-use
    step(0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 0, 0);
    // memory wait: 4 unacked cycles then ack
    for (int i = 0; i < 4; i++) step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
    step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1);
    step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
    // request acked in the same cycle: no stall
    step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1);
    // timeout, redirect during the error cycle is dropped
    for (int i = 0; i < TIMEOUT + 1; i++) step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
    step(0, 5'd3, 5'd0, 1, 0, 5'd3, 1, 1, 0, 0);
    step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
    // redirect held during stall, acted on once the ack arrives
    step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0);
    step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 1);
    // reset while waiting
    for (int i = 0; i < 2; i++) step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
    step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
    step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
    // reset on the cycle that would have timed out: no error pulse
    for (int i = 0; i < TIMEOUT; i++) step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
    step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
    step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 63) == 0,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: maximum MEM_WAIT cycles before abort.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 D_rs1, D_rs2  in  5 each  decode-stage source register indices.
REQ-005 D_use_rs1, D_use_rs2  in  1 each  decode instruction reads rs1/rs2.
REQ-006 E_rd  in  5  execute-stage destination index; E_is_load  in  1  execute instruction is a load.
REQ-007 E_redirect  in  1  taken branch/jump resolved in execute.
REQ-008 M_mem_req  in  1  memory-stage data access pending; dmem_ack  in  1  data memory completion.
REQ-009 F_stall, D_stall, E_stall, M_stall  out  1 each  hold the matching pipeline register.
REQ-010 D_flush, E_flush  out  1 each  load NOP (32'h00000013) into the IF/ID and ID/EX registers.
REQ-011 mem_err  out  1  one-cycle pulse on data-access timeout.
REQ-012 stall_cycles, flush_events  out  32 each  performance counters.

Function
REQ-013 FSM states: IDLE, MEM_WAIT, ERR.
REQ-014 IDLE to MEM_WAIT when M_mem_req=1 and dmem_ack=0; a request acked in the same cycle stays in IDLE and causes no stall.
REQ-015 MEM_WAIT to IDLE on dmem_ack=1.
REQ-016 MEM_WAIT to ERR when the wait counter reaches MEM_TIMEOUT without ack.
REQ-017 ERR to IDLE unconditionally after 1 cycle; mem_err is registered and high only while in ERR.
REQ-018 Wait counter: 8 bits minimum, sized to hold MEM_TIMEOUT; cleared on MEM_WAIT entry; increments each MEM_WAIT cycle; never wraps.
REQ-019 Memory stall (IDLE with M_mem_req and no dmem_ack, or MEM_WAIT without dmem_ack): assert F_stall, D_stall, E_stall, M_stall; D_flush=E_flush=0.
REQ-020 During a memory stall, a pending E_redirect is held by E_stall and acted on in the first non-stalled cycle.
REQ-021 Redirect (no memory stall, E_redirect=1): assert D_flush=E_flush=1; all stalls=0; load-use detection is suppressed.
REQ-022 Load-use (no memory stall, no redirect): E_is_load=1 and E_rd≠0 and ((D_use_rs1 and D_rs1==E_rd) or (D_use_rs2 and D_rs2==E_rd)).
REQ-023 On load-use: F_stall=D_stall=1 and E_flush=1 for exactly one cycle; the next cycle sees the bubble and releases.
REQ-024 A register index of x0 never triggers load-use.
REQ-025 Priority: memory stall > redirect > load-use > none.
REQ-026 Stall and flush outputs are combinational from state and inputs; zero cycles of added latency.
REQ-027 ERR cycle: all stall and flush outputs are 0.

Reset
REQ-028 rst=1 at a clock edge: state=IDLE, wait counter=0, mem_err=0, stall_cycles=0, flush_events=0.
REQ-029 While rst=1, all stall and flush outputs are 0.
REQ-030 Reset asserted during MEM_WAIT or ERR aborts to IDLE with no mem_err pulse.

Configuration
REQ-031 Macro PIPELINE_CTRL_PERF_CNT_EN defined: stall_cycles increments on every cycle with F_stall=1.
REQ-032 With PIPELINE_CTRL_PERF_CNT_EN defined, flush_events increments on every cycle with D_flush or E_flush=1.
REQ-033 Both counters saturate at 32'hFFFFFFFF.
REQ-034 Macro undefined: the ports remain, are tied to 0, and no counter flops are synthesized.

Structure
REQ-035 Shared package pipeline_ctrl_pkg holds: state enum, NOP_INSTR=32'h00000013, REG_IDX_W=5.
REQ-036 A single sub-module, pipe_perf_cnt (saturating 32-bit counter with enable), is instantiated twice under the macro.

Verification
REQ-037 Scenario load-use: E_is_load=1, E_rd=5, D_rs1=5, D_use_rs1=1 -> one cycle of F_stall=D_stall=E_flush=1, then all 0.
REQ-038 Scenario x0: E_is_load=1, E_rd=0, D_rs1=0 -> no stall.
REQ-039 Scenario redirect vs load-use: E_redirect=1 with a load-use match -> D_flush=E_flush=1 and F_stall=0.
REQ-040 Scenario memory wait: M_mem_req=1, dmem_ack after 3 cycles -> 4 stall cycles, then IDLE; with the counter macro enabled, stall_cycles=4.
REQ-041 Scenario timeout: MEM_TIMEOUT=4, ack never arrives -> mem_err high for 1 cycle, then IDLE.
REQ-042 Scenario reset: rst asserted during MEM_WAIT -> next cycle IDLE with all outputs 0.
